// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset main controller.
// The state encodings are architectural: they are exposed on the debug state port.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Full control word driven onto the shared datapath.
  typedef struct packed {
    logic       pc_en;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_supported_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational map from controller state (plus memReady, opcode, zero) to the
// datapath control word. Holds no state of its own.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_e     i_state,
  input  logic       i_mem_ready,
  input  logic [5:0] i_op_code,
  input  logic       i_zero,
  output ctrl_t      o_ctrl
);

  always_comb begin
    // NOTE: the whole word is cleared first so every path assigns every field; no latches.
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.ior_d     = 1'b0;
        o_ctrl.alu_src_a = 1'b0;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_source = PCSRC_ALU;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_a = 1'b0;
        o_ctrl.alu_src_b = SRCB_IMM_SH2;
        o_ctrl.alu_op    = ALUOP_ADD;
        // Unsupported opcodes end the instruction right here.
        if (!is_supported_op(i_op_code)) begin
          o_ctrl.illegal_op = 1'b1;
          o_ctrl.instr_done = 1'b1;
        end
      end
      S_MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.ior_d    = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.reg_dst    = 1'b0;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.ior_d      = 1'b1;
        o_ctrl.instr_done = i_mem_ready;
      end
      S_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.mem_to_reg = 1'b0;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_B;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
        o_ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_source  = PCSRC_JUMP;
        o_ctrl.instr_done = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
    o_ctrl.pc_en = o_ctrl.pc_write | (o_ctrl.pc_write_cond & i_zero);
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle main controller: state register and next-state logic, with the
// control word from mc_ctrl_decode forced low while reset is held.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       resetN,
  input  logic [5:0] opCode,
  input  logic       zero,
  input  logic       memReady,
  output logic       pcEn,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSource,
  output logic       instrDone,
  output logic       illegalOp,
  output logic [3:0] state
);

  state_e r_state;
  state_e w_next_state;
  ctrl_t  w_ctrl_raw;
  ctrl_t  w_ctrl;

  // NOTE: state is sequential, so it is updated only with non-blocking assignments.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= S_FETCH;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:  w_next_state = memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opCode)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = S_EXEC;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_J:         w_next_state = S_JUMP;
          default:      w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opCode == OP_LW)      w_next_state = S_MEMRD;
        else if (opCode == OP_SW) w_next_state = S_MEMWR;
        else                      w_next_state = S_FETCH;
      end
      S_MEMRD:  w_next_state = memReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next_state = S_FETCH;
      S_MEMWR:  w_next_state = memReady ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next_state = S_RWB;
      S_RWB:    w_next_state = S_FETCH;
      S_BRANCH: w_next_state = S_FETCH;
      S_JUMP:   w_next_state = S_FETCH;
      default:  w_next_state = S_FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .i_state     (r_state),
    .i_mem_ready (memReady),
    .i_op_code   (opCode),
    .i_zero      (zero),
    .o_ctrl      (w_ctrl_raw)
  );

  // Gate with resetN so no strobe survives the asynchronous reset, even combinationally.
  assign w_ctrl = resetN ? w_ctrl_raw : '0;

  assign pcEn        = w_ctrl.pc_en;
  assign pcWrite     = w_ctrl.pc_write;
  assign pcWriteCond = w_ctrl.pc_write_cond;
  assign iorD        = w_ctrl.ior_d;
  assign memRead     = w_ctrl.mem_read;
  assign memWrite    = w_ctrl.mem_write;
  assign irWrite     = w_ctrl.ir_write;
  assign regDst      = w_ctrl.reg_dst;
  assign memToReg    = w_ctrl.mem_to_reg;
  assign regWrite    = w_ctrl.reg_write;
  assign aluSrcA     = w_ctrl.alu_src_a;
  assign aluSrcB     = w_ctrl.alu_src_b;
  assign aluOp       = w_ctrl.alu_op;
  assign pcSource    = w_ctrl.pc_source;
  assign instrDone   = w_ctrl.instr_done;
  assign illegalOp   = w_ctrl.illegal_op;
  assign state       = r_state;

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle main controller for the MIPS-subset processor: a Moore-style state machine that sequences the shared datapath (single memory, IR, register file, one ALU, PC) through fetch, decode, execute, memory and write-back steps. It supports R-type, lw, sw, beq and j. It replaces the single-cycle opcode decoder in the multi-cycle build and adds a memory-ready handshake so that slow memory stalls the sequence.

## Interface
Parameters: none.
- clk  in  1  rising-edge clock
- resetN  in  1  asynchronous, active-low reset
- opCode  in  6  IR[31:26]; stable from DECODE until instruction end (IR written only in FETCH)
- zero  in  1  ALU zero flag, used in BRANCH
- memReady  in  1  memory completes the current access this cycle
- pcEn  out  1  PC load enable = pcWrite | (pcWriteCond & zero)
- pcWrite, pcWriteCond  out  1 each  unconditional / conditional PC write
- iorD  out  1  memory address: 0=PC, 1=ALUOut
- memRead, memWrite  out  1 each  memory strobes
- irWrite  out  1  IR load
- regDst  out  1  0=rt, 1=rd
- memToReg  out  1  0=ALUOut, 1=MDR
- regWrite  out  1  register file write
- aluSrcA  out  1  0=PC, 1=A
- aluSrcB  out  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
- aluOp  out  2  00=add, 01=sub, 10=funct-decoded
- pcSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- instrDone  out  1  last cycle of an instruction
- illegalOp  out  1  unsupported opcode detected in DECODE
- state  out  4  current state, for debug

## Operation
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010.
- Outputs are combinational from state, except the memReady gating listed below. Every output not listed for a state is 0.
- FETCH(0):
  - memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00.
  - irWrite=pcWrite=memReady.
  - Next: DECODE if memReady=1, else stay in FETCH.
- DECODE(1): aluSrcA=0, aluSrcB=11, aluOp=00 (branch target into ALUOut). Next state by opcode:
  - lw or sw -> MEMADR
  - R -> EXEC
  - beq -> BRANCH
  - j -> JUMP
  - any other opcode -> FETCH, with illegalOp=1 and instrDone=1
- MEMADR(2): aluSrcA=1, aluSrcB=10, aluOp=00. Next: MEMRD for lw, MEMWR for sw.
- MEMRD(3): memRead=1, iorD=1. Next: MEMWB if memReady=1, else stay.
- MEMWB(4): regDst=0, memToReg=1, regWrite=1, instrDone=1. Next: FETCH.
- MEMWR(5): memWrite=1, iorD=1, instrDone=memReady. Next: FETCH if memReady=1, else stay.
- EXEC(6): aluSrcA=1, aluSrcB=00, aluOp=10. Next: RWB.
- RWB(7): regDst=1, memToReg=0, regWrite=1, instrDone=1. Next: FETCH.
- BRANCH(8): aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01, instrDone=1. Next: FETCH.
- JUMP(9): pcWrite=1, pcSource=10, instrDone=1. Next: FETCH.
- Encodings 10–15 are unreachable. If entered, all outputs are 0 and the next state is FETCH.

## Timing
- Reset: resetN=0 asynchronously forces state=FETCH. While resetN=0, every control output is forced to 0 and state reads 0. FETCH outputs appear as soon as resetN rises.
- Asserting resetN mid-instruction aborts it immediately. No memory strobe or write enable remains asserted while resetN=0.
- State changes only on a rising clk edge. memReady and zero are sampled in the same cycle they are used.
- Instruction latency with memReady held at 1:
  - lw 5 cycles; sw, R-type 4; beq, j 3; illegal opcode 2.
  - Each memReady=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Back-to-back instructions: the cycle after instrDone=1 is always FETCH.
- beq: pcEn is high in BRANCH only when zero=1.

## Structure
- Package mc_ctrl_pkg contains:
  - state enum (4-bit encodings 0–9 as above)
  - opcode constants
  - aluOp, aluSrcB and pcSource code constants
- The top level holds the state register and next-state logic.
- Sub-module mc_ctrl_decode is a pure combinational map from (state, memReady, opCode, zero) to the control outputs; it is verified separately.

## Test plan
- R-type (opCode=000000), memReady=1: states 0,1,6,7,0; regWrite=1, regDst=1 only in state 7; instrDone in cycle 4.
- lw with memReady low for 2 cycles in MEMRD: states 0,1,2,3,3,3,4,0; memRead=1, iorD=1 throughout state 3; regWrite=1, memToReg=1 in state 4.
- beq twice, zero=1 then zero=0: pcEn=1 then pcEn=0 in BRANCH, with pcSource=01 in both cases.
- j: pcWrite=1, pcSource=10 in state 9; 3-cycle instruction.
- opCode=111111: illegalOp=1 and instrDone=1 in DECODE, then FETCH; regWrite and memWrite never asserted.
- resetN pulled low during MEMWR with memReady=0: memWrite drops to 0 immediately (asynchronously); state=0 after release; FETCH outputs present.
